mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_sync_ram.sv | 24 ++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side responder: FSM encoding and
// wait-counter sizing.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_responder_sync_ram.sv
// Single-port synchronous word RAM, read-first, no reset on the array or the
// read register.
module sync_ram #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // array write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Four-phase req/ack memory responder: latches a word request, waits a
// programmable number of cycles, accesses the RAM and holds ack until req drops.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [WIDTH-1:0]        ram_rdata;

  // The RAM is addressed by the live addr while idle so the read word is
  // already registered when a zero-latency request reaches its access edge.
  sync_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // next-state, latch and RAM-control logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        ram_addr = addr;
        if (req) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_CNT;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_ACK;
          // a reset landing on the access edge must not commit the write
          if (we_q) begin
            ram_we = reset;
          end else begin
            rdata_d = ram_rdata;
          end
        end
      end
      ST_ACK: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, counter, request latches and read-data register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {WIDTH{1'b0}};
      rdata_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack   = (state_q == ST_ACK);
  assign busy  = (state_q != ST_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: two instances (LATENCY 2
// and 0) checked against a word-array model with latency and rdata rules.
module tb_mem_responder;

  localparam int W     = 16;
  localparam int AW    = 10;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_a, we_a, ack_a, busy_a;
  logic [AW-1:0] addr_a;
  logic [W-1:0]  wdata_a, rdata_a;
  logic          req_b, we_b, ack_b, busy_b;
  logic [AW-1:0] addr_b;
  logic [W-1:0]  wdata_b, rdata_b;

  mem_responder #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a)
  );

  mem_responder #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  bit [W-1:0]   mem_a [int];
  bit [W-1:0]   mem_b [int];
  logic [W-1:0] rd_exp_a = '0;
  logic [W-1:0] rd_exp_b = '0;

  task automatic drive(input int s, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
    if (s == 0) begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end
  endtask

  function automatic logic get_ack(input int s);
    return (s == 0) ? ack_a : ack_b;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [W-1:0] get_rdata(input int s);
    return (s == 0) ? rdata_a : rdata_b;
  endfunction
  function automatic int lat_of(input int s);
    return (s == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model view: a write updates the word array, a read loads rdata from it.
  task automatic model_access(input int s, input logic w, input logic [AW-1:0] a,
                              input logic [W-1:0] d);
    if (s == 0) begin
      if (w) mem_a[int'(a)] = d; else rd_exp_a = mem_a[int'(a)];
    end else begin
      if (w) mem_b[int'(a)] = d; else rd_exp_b = mem_b[int'(a)];
    end
  endtask

  function automatic logic [W-1:0] exp_rdata(input int s);
    return (s == 0) ? rd_exp_a : rd_exp_b;
  endfunction

  // One full handshake. mode: 0 inputs steady, 1 random changes during WAIT,
  // 2 addr+1 and wdata all-ones during WAIT.
  task automatic txn(input int s, input logic w, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input int mode, input string tag);
    int  n;
    bit  got;
    logic [AW-1:0] a1;
    n = 0;
    got = 1'b0;
    a1 = a + 10'd1;
    drive(s, 1'b1, w, a, d);
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      n++;
      if (get_ack(s)) got = 1'b1;
      else if (mode == 1) drive(s, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), W'($urandom));
      else if (mode == 2) drive(s, 1'b1, w, a1, 16'hFFFF);
    end
    model_access(s, w, a, d);
    checks++;
    if (!got || n != lat_of(s) + 2) begin
      errors++;
      $display("FAIL latency_%s: ack seen=%0d after %0d edges, required after %0d edges",
               tag, got, n, lat_of(s) + 2);
    end
    checks++;
    if (get_rdata(s) !== exp_rdata(s)) begin
      errors++;
      $display("FAIL rdata_%s: got 0x%04h, required 0x%04h", tag, get_rdata(s), exp_rdata(s));
    end
    checks++;
    if (get_busy(s) !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_ack_%s: got %b, required 1", tag, get_busy(s));
    end
    drive(s, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom), W'($urandom));
    tick();
    checks++;
    if (get_ack(s) !== 1'b0 || get_busy(s) !== 1'b0) begin
      errors++;
      $display("FAIL release_%s: ack=%b busy=%b, required 0 0", tag, get_ack(s), get_busy(s));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1'b1, 1'b1, 10'h001, 16'h1111);
    drive(1, 1'b1, 1'b1, 10'h001, 16'h1111);
    tick();
    tick();
    checks++;
    if (ack_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_a: ack=%b busy=%b rdata=0x%04h, required 0 0 0x0000", ack_a, busy_a, rdata_a);
    end
    checks++;
    if (ack_b !== 1'b0 || busy_b !== 1'b0 || rdata_b !== 16'h0000) begin
      errors++;
      $display("FAIL reset_b: ack=%b busy=%b rdata=0x%04h, required 0 0 0x0000", ack_b, busy_b, rdata_b);
    end
    drive(0, 1'b0, 1'b0, 10'h000, 16'h0000);
    drive(1, 1'b0, 1'b0, 10'h000, 16'h0000);
    reset = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy_a=%b busy_b=%b, required 0 0", busy_a, busy_b);
    end
    rd_exp_a = '0;
    rd_exp_b = '0;
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 10'h005, 16'hBEEF, 0, "wr_beef");
    txn(0, 1'b0, 10'h005, 16'h0000, 0, "rd_beef");
  endtask

  task automatic test_stability();
    txn(0, 1'b1, 10'h011, 16'h5A5A, 0, "wr_011");
    txn(0, 1'b1, 10'h010, 16'h1234, 2, "wr_010_changing");
    txn(0, 1'b0, 10'h010, 16'h0000, 0, "rd_010");
    txn(0, 1'b0, 10'h011, 16'h0000, 0, "rd_011");
  endtask

  task automatic test_zero_latency();
    txn(1, 1'b1, 10'h005, 16'h7777, 0, "z_wr");
    txn(1, 1'b0, 10'h005, 16'h0000, 0, "z_rd");
  endtask

  task automatic test_abort();
    txn(0, 1'b1, 10'h020, 16'h1111, 0, "abort_pre");
    drive(0, 1'b1, 1'b1, 10'h020, 16'hAAAA);
    tick();
    tick();
    tick();
    // next edge would perform the write; reset is asserted for it
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 10'h000, 16'h0000);
    tick();
    checks++;
    if (ack_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state: ack=%b busy=%b rdata=0x%04h, required 0 0 0x0000", ack_a, busy_a, rdata_a);
    end
    rd_exp_a = '0;
    rd_exp_b = '0;
    reset = 1'b1;
    tick();
    txn(0, 1'b0, 10'h020, 16'h0000, 0, "abort_rd");
  endtask

  task automatic test_violation();
    int ack_cycles;
    int first;
    logic [W-1:0] d;
    d = W'($urandom);
    ack_cycles = 0;
    first = -1;
    drive(0, 1'b1, 1'b1, 10'h030, d);
    tick();
    drive(0, 1'b0, 1'b0, 10'h3FF, 16'h0000);
    for (int i = 2; i <= 9; i++) begin
      tick();
      if (ack_a === 1'b1) begin
        ack_cycles++;
        if (first < 0) first = i;
      end
    end
    mem_a[32'h030] = d;
    checks++;
    if (ack_cycles != 1 || first != LAT_A + 2) begin
      errors++;
      $display("FAIL violation_ack: %0d ack cycles first at edge %0d, required 1 at edge %0d",
               ack_cycles, first, LAT_A + 2);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL violation_busy: got %b, required 0", busy_a);
    end
    txn(0, 1'b0, 10'h030, 16'h0000, 0, "violation_rd");
  endtask

  task automatic test_held_req();
    int  bad;
    bit  got;
    got = 1'b0;
    bad = 0;
    drive(0, 1'b1, 1'b1, 10'h040, 16'hC0DE);
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (ack_a === 1'b1) got = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 1'b1, 10'h040, W'($urandom_range(0, 16'hBFFF)));
      tick();
      if (ack_a !== 1'b1 || busy_a !== 1'b1) bad++;
    end
    mem_a[32'h040] = 16'hC0DE;
    checks++;
    if (!got || bad != 0) begin
      errors++;
      $display("FAIL held_req: ack seen=%b, %0d cycles not holding ack/busy, required 1 and 0", got, bad);
    end
    drive(0, 1'b0, 1'b0, 10'h000, 16'h0000);
    tick();
    txn(0, 1'b0, 10'h040, 16'h0000, 0, "held_rd");
  endtask

  task automatic test_random(input int s, input int count);
    logic          w;
    logic [AW-1:0] a;
    bit            known;
    for (int i = 0; i < count; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(10'h100, 10'h10F));
      known = (s == 0) ? mem_a.exists(int'(a)) : mem_b.exists(int'(a));
      if (!known) w = 1'b1;
      txn(s, w, a, W'($urandom), int'($urandom_range(0, 1)), $sformatf("rand%0d_%0d", s, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_stability();
    test_zero_latency();
    test_abort();
    test_violation();
    test_held_req();
    test_random(0, 25);
    test_random(1, 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
